// File: rtl/aes_192_wb_sequencer.sv
// Wishbone master that drives a memory-mapped AES-192 slave, one 128-bit block at a time.
// Rewrites the key only when it has changed, then writes the data, starts the core, polls and reads back.
module aes_192_wb_sequencer #(
  parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [191:0] key_i,
  input  logic         key_load_i,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [127:0] blk_data_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [127:0] res_data_o,
  output logic         busy_o,
  output logic         err_o,
  output logic [31:0]  wb_adr_o,
  output logic [31:0]  wb_dat_o,
  input  logic [31:0]  wb_dat_i,
  output logic [3:0]   wb_sel_o,
  output logic         wb_we_o,
  output logic         wb_stb_o,
  output logic         wb_cyc_o,
  input  logic         wb_ack_i
);

  localparam logic [15:0] PollLimit = 16'(POLL_LIMIT);

  typedef enum logic [2:0] {
    StIdle, StWkey, StWdata, StStart, StPoll, StRdres, StOut
  } state_e;

  state_e       state_q, state_d;
  logic         gap_q, gap_d;
  logic [2:0]   idx_q, idx_d;
  logic [15:0]  poll_q, poll_d;
  logic [191:0] key_q, key_d;
  logic         key_dirty_q, key_dirty_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] res_q, res_d;
  logic         err_q, err_d;

  logic         xfer;
  logic         wr;
  logic         ack;
  logic [3:0]   word_idx;
  logic [31:0]  wr_data;

  // Bus request decode; gap_q forces the idle cycle that follows every acknowledged transfer.
  always_comb begin
    xfer     = 1'b0;
    wr       = 1'b0;
    word_idx = '0;
    wr_data  = '0;
    unique case (state_q)
      StWkey: begin
        xfer     = !gap_q;
        wr       = 1'b1;
        word_idx = 4'd5 + {1'b0, idx_q};
        wr_data  = key_q[{idx_q, 5'b0} +: 32];
      end
      StWdata: begin
        xfer     = !gap_q;
        wr       = 1'b1;
        word_idx = 4'd1 + {2'b0, idx_q[1:0]};
        wr_data  = blk_q[{idx_q[1:0], 5'b0} +: 32];
      end
      StStart: begin
        xfer     = !gap_q;
        wr       = 1'b1;
        word_idx = 4'd0;
        wr_data  = 32'h1;
      end
      StPoll: begin
        xfer     = !gap_q;
        word_idx = 4'd11;
      end
      StRdres: begin
        xfer     = !gap_q;
        word_idx = 4'd12 + {2'b0, idx_q[1:0]};
      end
      default: ;
    endcase
  end

  assign ack         = xfer & wb_ack_i;
  assign wb_cyc_o    = xfer;
  assign wb_stb_o    = xfer;
  assign wb_we_o     = xfer & wr;
  assign wb_sel_o    = 4'hF;
  assign wb_adr_o    = xfer ? BASE_ADR + {26'd0, word_idx, 2'b00} : '0;
  assign wb_dat_o    = (xfer & wr) ? wr_data : '0;
  assign blk_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign res_valid_o = (state_q == StOut);
  assign res_data_o  = res_q;
  assign err_o       = err_q;

  always_comb begin
    state_d     = state_q;
    gap_d       = 1'b0;
    idx_d       = idx_q;
    poll_d      = poll_q;
    key_d       = key_q;
    key_dirty_d = key_dirty_q;
    blk_d       = blk_q;
    res_d       = res_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (key_load_i) begin
          key_d       = key_i;
          key_dirty_d = 1'b1;
        end
        if (blk_valid_i) begin
          blk_d   = blk_data_i;
          state_d = (key_dirty_q || key_load_i) ? StWkey : StWdata;
        end
      end
      StWkey: begin
        if (ack) begin
          gap_d = 1'b1;
          if (idx_q == 3'd5) begin
            key_dirty_d = 1'b0;
            state_d     = StWdata;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StWdata: begin
        if (ack) begin
          gap_d = 1'b1;
          if (idx_q == 3'd3) state_d = StStart;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      StStart: begin
        if (ack) begin
          gap_d   = 1'b1;
          state_d = StPoll;
        end
      end
      StPoll: begin
        if (ack) begin
          gap_d  = 1'b1;
          poll_d = poll_q + 16'd1;
          if (wb_dat_i[0]) begin
            state_d = StRdres;
          end else if (poll_q + 16'd1 == PollLimit) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRdres: begin
        if (ack) begin
          gap_d = 1'b1;
          res_d[{idx_q[1:0], 5'b0} +: 32] = wb_dat_i;
          if (idx_q == 3'd3) state_d = StOut;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      StOut: begin
        if (res_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Word and poll counters restart on every state entry.
    if (state_d != state_q) begin
      idx_d  = '0;
      poll_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      gap_q       <= 1'b0;
      idx_q       <= '0;
      poll_q      <= '0;
      key_q       <= '0;
      key_dirty_q <= 1'b1;
      blk_q       <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      poll_q      <= poll_d;
      key_q       <= key_d;
      key_dirty_q <= key_dirty_d;
      blk_q       <= blk_d;
      res_q       <= res_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/aes_192_wb_sequencer.md
# aes_192_wb_sequencer

Wishbone master that streams 128-bit plaintext blocks through the memory-mapped AES-192 Wishbone slave, which sits directly downstream. It accepts a key and blocks over valid/ready handshakes. For each block it writes the key words (only when the key has changed), writes the four data words and pulses start. It then polls the ready register, reads back the four result words and presents the ciphertext on a valid/ready output. It relieves the CPU of per-block register traffic.

## Interface
- BASE_ADR, 32'h0000_0000, byte base address of the AES slave
- POLL_LIMIT, 1024, maximum ready-poll reads per block before timeout (16-bit counter)

- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- key_i  in  192  key; key_i[31:0] is key word 0
- key_load_i  in  1  capture key_i; honoured only while busy_o=0
- blk_valid_i  in  1  input block valid
- blk_ready_o  out  1  input block accepted when valid & ready
- blk_data_i  in  128  plaintext; [31:0] is data word 0
- res_valid_o  out  1  ciphertext valid
- res_ready_i  in  1  consumer ready
- res_data_o  out  128  ciphertext; [31:0] from result word 0
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky poll timeout
- wb_adr_o  out  32  master address
- wb_dat_o  out  32  master write data
- wb_dat_i  in  32  master read data
- wb_sel_o  out  4  always 4'hF
- wb_we_o, wb_stb_o, wb_cyc_o  out  1 each  Wishbone classic controls
- wb_ack_i  in  1  slave acknowledge

## Operation
- Slave word map (address = BASE_ADR + 4*index):
  - 0: start (bit0)
  - 1–4: data words 0–3
  - 5–10: key words 0–5
  - 11: ready (bit0)
  - 12–15: result words 0–3
- Transfer rule:
  - Drive cyc/stb/adr/we/dat and hold them until wb_ack_i is sampled high.
  - Then deassert cyc/stb for exactly one idle cycle.
  - There is no pipelining and no bursts.
- key_dirty:
  - Set by reset and by an honoured key_load_i.
  - key_load_i copies key_i into the shadow key register.
  - Cleared when WKEY completes.
- States:
  - IDLE: blk_ready_o=1. On a handshake, latch blk_data_i and go to WKEY if key_dirty, else to WDATA. A key_load_i in the same cycle applies to this block.
  - WKEY: write shadow key words 0..5 to indices 5..10 in order, then go to WDATA.
  - WDATA: write data words 0..3 to indices 1..4, then go to START.
  - START: write 32'h1 to index 0. The idle cycle that follows deasserts start at the slave, producing the single-cycle pulse. Then go to POLL.
  - POLL: read index 11 and increment the poll counter.
    - If bit0=1, go to RDRES.
    - Else, if the counter equals POLL_LIMIT, set err_o, discard the block and go to IDLE.
    - Else repeat the read.
  - RDRES: read indices 12..15 into res_data_o words 0..3, then go to OUT.
  - OUT: res_valid_o=1 and res_data_o held stable until res_ready_i; then go to IDLE. blk_ready_o stays 0 here.
- The poll counter and word index counter are cleared on every state entry.

## Timing
- Reset values:
  - All Wishbone controls 0, wb_adr_o/wb_dat_o 0, wb_sel_o 4'hF.
  - res_valid_o 0, res_data_o 0, err_o 0.
  - busy_o 0, blk_ready_o 1 (IDLE), key_dirty 1.
- Assertion of wb_rst_i mid-operation immediately drops cyc/stb and aborts the block. No result is emitted and no partial state survives.
- Latency with an always-ack slave, block accepted at cycle T:
  - Key clean, ready on the first poll: transfers occur at T+1, T+3, …; the last result read completes at T+19; res_valid_o rises at T+20.
  - Key dirty: add 12 cycles.
  - Each poll returning 0: add 2 cycles.
- A held-low wb_ack_i stretches the current transfer indefinitely. Only polls count toward POLL_LIMIT.
- Back-to-back blocks: the next block is accepted no earlier than the cycle after the res_valid_o & res_ready_i handshake.
- err_o is cleared only by reset.

## Test plan
- FIPS-197 AES-192 vector:
  - Stimulus: key_load_i with key 000102030405060708090a0b0c0d0e0f1011121314151617, block 00112233445566778899aabbccddeeff.
  - Required response: writes adr 0x14 = 14151617 … adr 0x28 = 00010203, then adr 0x04 = ccddeeff … adr 0x10 = 00112233, then adr 0x00 = 1. res_data_o = dda97ca4864cdfe06eaf70a0ec0d7191 with res_valid_o at T+32.
- Second block, same key: no writes to indices 5–10 occur; res_valid_o at T+20.
- Slave model returns ready=0 for 3 polls: exactly 4 reads of adr 0x2C; res_valid_o at T+26.
- POLL_LIMIT=4 and ready never set:
  - Exactly 4 polls, then err_o=1 and res_valid_o never asserts.
  - blk_ready_o=1 on the next cycle.
- res_ready_i held low 10 cycles: res_valid_o and res_data_o stay stable, blk_ready_o=0, with no Wishbone activity.
- Reset asserted during WDATA: wb_stb_o/wb_cyc_o drop the same cycle. After release the next block rewrites the key first.
